// File: rtl/fir_mac_sequencer_if.sv
// Bundle of the frame-control handshake, the shared sample/coefficient RAM
// read port and the shared ALU operand/result lines around the FIR sequencer.
// The master side is the sequencer; the slave side is everything around it.
interface fir_mac_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] num_taps;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] coeff_data;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;

    modport master (
        input  start, num_taps, base_addr,
        input  sample_data, coeff_data, alu_result,
        output busy, done, result, zero,
        output mem_rd_en, mem_addr,
        output alu_a, alu_b, alu_sel
    );

    modport slave (
        output start, num_taps, base_addr,
        output sample_data, coeff_data, alu_result,
        input  busy, done, result, zero,
        input  mem_rd_en, mem_addr,
        input  alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR dot-product sequencer: walks N taps starting at a base address, fetching
// a sample/coefficient pair per tap, multiplying them on the shared ALU and
// adding the product into a private accumulator (3 cycles per tap), then
// reports the wrapped 16-bit sum with a one-cycle done pulse.
module fir_mac_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_mac_sequencer_if.master   bus
);

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_MUL  = 4'b0010;
    localparam logic [3:0] SEL_NOP  = 4'b1101;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MUL,
        ACC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] taps_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] product_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    logic              last_tap;
    logic [ADDR_W-1:0] fetch_addr;

    // The tap index counts 0..N-1; the address wraps naturally in ADDR_W bits.
    assign last_tap   = (index_q == (taps_q - ADDR_W'(1)));
    assign fetch_addr = base_q + index_q;

    assign bus.result = result_q;
    assign bus.zero   = zero_q;

    // State register; reset drops straight back to IDLE, abandoning any job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs, so every output is steady for the whole state cycle.
    always_comb begin
        state_next    = state;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = addr_q;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_sel   = SEL_NOP;

        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_next = (bus.num_taps == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = fetch_addr;
                state_next    = MUL;
            end
            MUL: begin
                bus.alu_a   = bus.sample_data;
                bus.alu_b   = bus.coeff_data;
                bus.alu_sel = SEL_MUL;
                state_next  = ACC;
            end
            ACC: begin
                bus.alu_a   = acc_q;
                bus.alu_b   = product_q;
                bus.alu_sel = SEL_ADD;
                state_next  = last_tap ? DONE : FETCH;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job datapath: capture on start, hold the fetch address, latch product and sum, and publish the result on the way into DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps_q    <= '0;
            base_q    <= '0;
            index_q   <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            product_q <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        taps_q  <= bus.num_taps;
                        base_q  <= bus.base_addr;
                        acc_q   <= '0;
                        index_q <= '0;
                        if (bus.num_taps == '0) begin
                            result_q <= '0;
                            zero_q   <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    addr_q <= fetch_addr;
                end
                MUL: begin
                    product_q <= bus.alu_result;
                end
                ACC: begin
                    acc_q   <= bus.alu_result;
                    index_q <= index_q + ADDR_W'(1);
                    if (last_tap) begin
                        result_q <= bus.alu_result;
                        zero_q   <= (bus.alu_result == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: models the RAMs and the ALU,
// runs a table of hand-computed jobs, multi-cycle corner sequences and
// randomized jobs checked against a plain-arithmetic dot-product model.
module tb_fir_mac_sequencer;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int MAX_CYC = 3 * 256 + 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fir_mac_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] sample_mem [256];
    logic [15:0] coeff_mem  [256];

    // Synchronous-read RAM pair: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.sample_data <= sample_mem[bus.mem_addr];
            bus.coeff_data  <= coeff_mem[bus.mem_addr];
        end
    end

    // Behavioural shared ALU: low half of multiply, wrapping add, zero otherwise.
    always_comb begin
        case (bus.alu_sel)
            4'b0010: bus.alu_result = bus.alu_a * bus.alu_b;
            4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [15:0] job_result;
    logic        job_zero;
    int          job_cycles;
    int          job_rd;
    int          job_addr_errs;
    int          job_op_errs;
    int          job_busy_errs;
    int          job_extra_done;
    int          job_timeout;

    typedef struct {
        logic [7:0]       base;
        logic [7:0]       n;
        logic [3:0][15:0] s;
        logic [3:0][15:0] c;
        logic [15:0]      exp_res;
        logic             exp_zero;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference dot product over the RAM images, wrapping address and sum.
    function automatic logic [15:0] model_fir(input logic [7:0] base, input int n);
        logic [15:0] acc;
        logic [7:0]  a;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            a   = 8'(int'(base) + i);
            acc = acc + sample_mem[a] * coeff_mem[a];
        end
        return acc;
    endfunction

    // Launch one job and observe it cycle by cycle; inject_at re-pulses start in that cycle (0 = never).
    task automatic apply_stimulus(input logic [7:0] base, input logic [7:0] n, input int inject_at);
        logic [15:0] acc_m;
        logic [15:0] prod_m;
        logic [7:0]  a;
        int          tap;
        bit          finished;
        job_result     = 'x;
        job_zero       = 1'bx;
        job_cycles     = -1;
        job_rd         = 0;
        job_addr_errs  = 0;
        job_op_errs    = 0;
        job_busy_errs  = 0;
        job_extra_done = 0;
        acc_m          = '0;
        prod_m         = '0;
        finished       = 1'b0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_taps  = n;
        bus.base_addr = base;
        for (int cyc = 1; cyc <= MAX_CYC && !finished; cyc++) begin
            @(negedge clk);
            tap = (cyc - 1) / 3;
            a   = 8'(int'(base) + tap);
            if (bus.busy !== 1'b1) job_busy_errs++;
            if (bus.mem_rd_en === 1'b1) begin
                job_rd++;
                if (bus.mem_addr !== a || (cyc % 3) != 1) job_addr_errs++;
            end
            if (cyc <= 3 * int'(n)) begin
                if ((cyc % 3) == 2) begin
                    if (bus.alu_sel !== 4'b0010 || bus.alu_a !== sample_mem[a] || bus.alu_b !== coeff_mem[a])
                        job_op_errs++;
                    prod_m = sample_mem[a] * coeff_mem[a];
                end else if ((cyc % 3) == 0) begin
                    if (bus.alu_sel !== 4'b0000 || bus.alu_a !== acc_m || bus.alu_b !== prod_m)
                        job_op_errs++;
                    acc_m = acc_m + prod_m;
                end
            end
            if (bus.done === 1'b1) begin
                finished   = 1'b1;
                job_cycles = cyc;
                job_result = bus.result;
                job_zero   = bus.zero;
            end
            bus.start = (cyc == inject_at);
            if (cyc == inject_at) begin
                bus.num_taps  = 8'd5;
                bus.base_addr = base + 8'h40;
            end
        end
        job_timeout = finished ? 0 : 1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) job_extra_done++;
            if (bus.busy !== 1'b0) job_busy_errs++;
            bus.start = 1'b0;
        end
    endtask

    task automatic check_job(input string tag, input logic [7:0] n, input logic [15:0] exp_res, input logic exp_zero);
        check_output({tag, " timeout"}, job_timeout, 0);
        check_output({tag, " result"}, job_result, exp_res);
        check_output({tag, " zero"}, job_zero, exp_zero);
        check_output({tag, " done_cycle"}, job_cycles, 3 * int'(n) + 1);
        check_output({tag, " rd_count"}, job_rd, int'(n));
        check_output({tag, " addr_errs"}, job_addr_errs, 0);
        check_output({tag, " alu_errs"}, job_op_errs, 0);
        check_output({tag, " busy_errs"}, job_busy_errs, 0);
        check_output({tag, " extra_done"}, job_extra_done, 0);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < int'(v.n) && i < 4; i++) begin
            sample_mem[8'(int'(v.base) + i)] = v.s[i];
            coeff_mem[8'(int'(v.base) + i)]  = v.c[i];
        end
    endtask

    initial begin
        int          dones;
        logic [7:0]  rb;
        logic [7:0]  rn;

        vecs[0] = '{8'h10, 8'd4, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 16'h0046, 1'b0};
        vecs[1] = '{8'h20, 8'd1, {16'd0, 16'd0, 16'd0, 16'h0100}, {16'd0, 16'd0, 16'd0, 16'h0100}, 16'h0000, 1'b1};
        vecs[2] = '{8'h30, 8'd2, {16'd0, 16'd0, 16'h0001, 16'hFFFF}, {16'd0, 16'd0, 16'h0001, 16'h0001}, 16'h0000, 1'b1};
        vecs[3] = '{8'h40, 8'd0, {16'd9, 16'd9, 16'd9, 16'd9}, {16'd9, 16'd9, 16'd9, 16'd9}, 16'h0000, 1'b1};
        vecs[4] = '{8'hFE, 8'd3, {16'd0, 16'd4, 16'd3, 16'd2}, {16'd0, 16'd10, 16'd10, 16'd10}, 16'h005A, 1'b0};
        vecs[5] = '{8'h50, 8'd2, {16'd0, 16'd0, 16'd4, 16'd3}, {16'd0, 16'd0, 16'd2, 16'd2}, 16'h000E, 1'b0};

        for (int i = 0; i < 256; i++) begin
            sample_mem[i] = 16'(i);
            coeff_mem[i]  = 16'(255 - i);
        end

        bus.start     = 1'b0;
        bus.num_taps  = '0;
        bus.base_addr = '0;
        rst           = 1'b0;

        // Reset held while clock runs and start toggles.
        repeat (4) begin
            @(negedge clk);
            bus.start    = ~bus.start;
            bus.num_taps = 8'd3;
        end
        @(negedge clk);
        check_output("rst busy", bus.busy, 0);
        check_output("rst done", bus.done, 0);
        check_output("rst result", bus.result, 0);
        check_output("rst zero", bus.zero, 0);
        check_output("rst mem_rd_en", bus.mem_rd_en, 0);
        check_output("rst mem_addr", bus.mem_addr, 0);
        check_output("rst alu_sel", bus.alu_sel, 4'b1101);
        check_output("rst alu_a", bus.alu_a, 0);
        check_output("rst alu_b", bus.alu_b, 0);
        bus.start = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check_output("idle busy", bus.busy, 0);

        // Hand-computed job table.
        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            apply_stimulus(vecs[v].base, vecs[v].n, 0);
            check_job($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_res, vecs[v].exp_zero);
        end

        // Start pulsed during MUL with different parameters must be ignored.
        load_vec(vecs[4]);
        apply_stimulus(8'hFE, 8'd3, 2);
        check_job("ign_mul", 8'd3, 16'h005A, 1'b0);

        // Start pulsed in the DONE cycle must also be ignored.
        apply_stimulus(8'hFE, 8'd3, 10);
        check_job("ign_done", 8'd3, 16'h005A, 1'b0);

        // Asynchronous reset in the third ACC of an 8-tap job.
        for (int i = 0; i < 8; i++) begin
            sample_mem[8'h60 + i] = 16'($urandom_range(1, 100));
            coeff_mem[8'h60 + i]  = 16'($urandom_range(1, 100));
        end
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_taps  = 8'd8;
        bus.base_addr = 8'h60;
        repeat (9) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_output("mid acc sel", bus.alu_sel, 4'b0000);
        check_output("mid busy", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check_output("async busy", bus.busy, 0);
        check_output("async result", bus.result, 0);
        check_output("async alu_sel", bus.alu_sel, 4'b1101);
        check_output("async alu_a", bus.alu_a, 0);
        check_output("async rd_en", bus.mem_rd_en, 0);
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check_output("abort no done", dones, 0);
        rst = 1'b1;
        apply_stimulus(8'h50, 8'd2, 0);
        check_job("post_rst", 8'd2, 16'h000E, 1'b0);

        // Randomized jobs against the dot-product model.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 256; i++) begin
                sample_mem[i] = 16'($urandom);
                coeff_mem[i]  = 16'($urandom);
            end
            rb = 8'($urandom);
            rn = (t == 19) ? 8'd255 : 8'($urandom_range(0, 12));
            apply_stimulus(rb, rn, 0);
            check_job($sformatf("rand%0d", t), rn, model_fir(rb, int'(rn)), model_fir(rb, int'(rn)) == 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Sequences the shared 16-bit ALU to compute an audio FIR dot product, result = sum over i of sample[base+i] * coeff[base+i] for i = 0..num_taps-1.
- Issues sample/coefficient memory reads.
- Drives ALU operand and select lines: multiply (sel 0010), then add (sel 0000) into an internal accumulator.
- Reports the filtered sample with a done pulse.
- Sits between the audio frame control logic, the sample/coefficient RAMs and the ALU.

Parameters:
DATA_W, 16, sample/coefficient/ALU data width
ADDR_W, 8, memory address and tap-count width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin a filter computation; sampled only in IDLE
num_taps  in  ADDR_W  number of taps N, captured with start
base_addr  in  ADDR_W  first tap address, captured with start
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse: result valid
result  out  DATA_W  final accumulator value, held until next done
zero  out  1  result == 0, updated with done
mem_rd_en  out  1  read strobe to sample and coefficient RAMs
mem_addr  out  ADDR_W  shared read address for both RAMs
sample_data  in  DATA_W  sample RAM read data; valid one cycle after mem_rd_en
coeff_data  in  DATA_W  coefficient RAM read data; valid one cycle after mem_rd_en
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_sel  out  4  ALU opcode
alu_result  in  DATA_W  ALU combinational result, same cycle

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, result=0, zero=0, mem_rd_en=0, mem_addr=0, alu_a=0, alu_b=0, alu_sel=4'b1101 (no-op); accumulator, tap index and product register cleared.
- Reset mid-operation aborts immediately. No done is issued and result returns to 0.
- States: IDLE, FETCH, MUL, ACC, DONE.
- IDLE:
  - alu_sel=1101, alu_a=alu_b=0.
  - On start=1, capture num_taps and base_addr, clear accumulator and index.
  - Go to FETCH, or to DONE if num_taps==0.
- FETCH: mem_rd_en=1, mem_addr=base_addr+index (mod 2^ADDR_W); next state MUL.
- MUL:
  - alu_a=sample_data, alu_b=coeff_data, alu_sel=0010.
  - Register alu_result as product; next state ACC.
- ACC:
  - alu_a=accumulator, alu_b=product, alu_sel=0000.
  - accumulator <= alu_result; index <= index+1.
  - Next state DONE if index==N-1, else FETCH.
- DONE:
  - done=1 for exactly this cycle.
  - result <= accumulator and zero <= (accumulator==0), both visible during this DONE cycle.
  - alu_sel=1101; next state IDLE.
- Outputs alu_a, alu_b, alu_sel, mem_rd_en and mem_addr are registered or decoded from state such that they are stable throughout each state cycle.
- Outside FETCH: mem_rd_en=0 and mem_addr holds its last value.
- Arithmetic: all ALU values are modulo 2^16. The product is the low 16 bits of the multiply; accumulation wraps with no saturation.
- Latency:
  - 3 cycles per tap.
  - done is high in the (3N+1)th cycle after the clock edge that sampled start.
  - For N=0, done is high in the 1st cycle after that edge.
- busy=1 in FETCH, MUL, ACC and DONE.
- start while not IDLE is ignored (no queueing). start asserted in the DONE cycle is also ignored; a new start is accepted in IDLE the following cycle.
- num_taps and base_addr changes after capture have no effect.
- Address wrap: base_addr+index wraps modulo 2^ADDR_W; N=255 is legal.

Test Plan:
1. Reset: hold rst=0, toggle clk and start -> busy=0, done=0, result=0, mem_rd_en=0, alu_sel=1101. Assert rst=0 mid-cycle -> outputs clear without waiting for a clock edge.
2. Basic FIR: base=0x10, N=4, samples 1,2,3,4, coeffs 5,6,7,8 -> mem_addr sequence 0x10..0x13, alu_sel pattern 0010,0000 repeated 4 times, done in cycle 13 after the start edge, result=70 (0x0046), zero=0.
3. Wrap/zero: N=1, sample=0x0100, coeff=0x0100 -> product truncated to 0x0000, result=0, zero=1. Then N=2 with samples 0xFFFF,0x0001 and coeffs 0x0001,0x0001 -> result=0x0000, zero=1.
4. Zero taps: start with N=0 -> done in the 1st cycle after start, result=0, zero=1, mem_rd_en never asserted.
5. Address wrap and ignored start: base=0xFE, N=3 -> addresses 0xFE,0xFF,0x00. Pulse start with different base/N during MUL -> ignored, result unchanged from the original job, exactly one done.
6. Reset mid-operation: N=8, drive rst=0 during the 3rd ACC -> immediate IDLE, no done. Release rst and restart with N=2, samples 3,4, coeffs 2,2 -> result=14, done in cycle 7 after the start edge.
